multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle RV32I control FSM that sequences the shared datapath: instruction register, single ALU, unified memory port and immediate sign extender. Decodes the latched instruction and drives per-state mux selects, write enables, ALU op and ImmSrc. Sits beside the datapath top and replaces the single-cycle combinational control unit. Also keeps a retired-instruction counter.

Parameters:
RETIRE_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
Instr  in  32  instruction register contents
Zero  in  1  ALU zero flag
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut
MemWrite  out  1  data memory write enable
IRWrite  out  1  instruction register enable
ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1 reg
ALUSrcB  out  2  00 RD2 reg, 01 ImmExt, 10 constant 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RegWrite  out  1  register file write enable
ImmSrc  out  2  00 I, 01 S, 10 B, 11 J; drives sign extender
IllegalInstr  out  1  one-cycle pulse on unsupported opcode
State  out  4  current state encoding (debug)
Retired  out  RETIRE_W  retired instruction count

Behaviour:
- Clocking/reset: one clock domain, synchronous active-high rst. rst: State=FETCH(0), Retired=0, IllegalInstr=0. While rst high all enables (PCWrite, IRWrite, MemWrite, RegWrite) forced 0. rst mid-instruction abandons it; no partial writes occur after the rst edge.
- States: FETCH0 DECODE1 MEMADR2 MEMREAD3 MEMWB4 MEMWRITE5 EXECR6 EXECI7 ALUWB8 BEQ9 JAL10. Other encodings go to FETCH.
- Transitions: FETCH->DECODE. DECODE on Instr[6:0]: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL (feature-gated), else FETCH with IllegalInstr=1 for that cycle. MEMADR->MEMREAD (lw) or MEMWRITE (sw). MEMREAD->MEMWB. EXECR/EXECI/JAL->ALUWB. MEMWB, MEMWRITE, ALUWB, BEQ->FETCH.
- Per-state outputs (unlisted enables 0, selects 00, ALUControl add):
  FETCH: AdrSrc0, IRWrite1, ALUSrcA00, ALUSrcB10, ResultSrc10, PCWrite1.
  DECODE: ALUSrcA01, ALUSrcB01 (branch target precompute).
  MEMADR: ALUSrcA10, ALUSrcB01. MEMREAD: AdrSrc1. MEMWB: ResultSrc01, RegWrite1. MEMWRITE: AdrSrc1, MemWrite1.
  EXECR: ALUSrcA10, ALUSrcB00, ALU decode. EXECI: ALUSrcA10, ALUSrcB01, ALU decode.
  ALUWB: ResultSrc00, RegWrite1.
  BEQ: ALUSrcA10, ALUSrcB00, sub, ResultSrc00, PCWrite=Zero.
  JAL: ALUSrcA01, ALUSrcB10, add, ResultSrc00, PCWrite1.
- ALU decode (EXECR/EXECI only): funct3 000 -> sub if R-type and Instr[30]=1 else add; 010 slt; 110 or; 111 and; other funct3 -> add.
- ImmSrc combinational from opcode in every state: lw/I-ALU 00, sw 01, beq 10, jal 11, else 00.
- Latency (cycles, FETCH inclusive): lw 5, sw 4, R 4, I 4, beq 3, jal 4, illegal 2.
- Retired: +1 on each exit from MEMWB, MEMWRITE, ALUWB, BEQ. Not on illegal. Wraps modulo 2^RETIRE_W. Update coincident with rst: reset wins.

Optional Feature:
MC_JAL_EN: defined -> opcode 1101111 goes DECODE->JAL->ALUWB->FETCH, ImmSrc=11, rd<=PC+4, PC<=target. Undefined -> JAL state unreachable, jal treated as illegal (IllegalInstr pulse, ImmSrc 00).

Test Plan:
- rst held 2 cycles then released -> State=0, Retired=0, FETCH asserts IRWrite=1, PCWrite=1, ALUSrcB=10 on first post-reset cycle.
- Instr=0x00802283 (lw x5,8(x0)) -> states 0,1,2,3,4,0; ImmSrc=00; RegWrite only in MEMWB with ResultSrc=01; Retired 0->1.
- Instr=0x00502223 (sw) -> states 0,1,2,5,0; ImmSrc=01; MemWrite=1 with AdrSrc=1 for exactly one cycle; RegWrite never 1.
- Instr=0x002081B3 then 0x402081B3 -> EXECR ALUControl 000 then 001; ALUWB RegWrite=1; Retired +2.
- Instr=0x00000463 (beq) with Zero=1 -> BEQ PCWrite=1; with Zero=0 -> PCWrite=0; ImmSrc=10; 3 cycles each.
- Instr=0xFFFFFFFF -> IllegalInstr=1 in DECODE only, back to FETCH, Retired unchanged. Instr=0x008000EF: with MC_JAL_EN states 0,1,10,8,0 and ImmSrc=11; without it, illegal pulse.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences IR, shared ALU, unified memory port and sign extender.
// Latency: lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles (FETCH inclusive); outputs combinational from state.
// No backpressure: advances every cycle; rst (sync, active-high) forces all enables low and returns to FETCH.
//
// Ports: clk/rst; Instr (latched instruction), Zero (ALU flag) in.
//        PCWrite/AdrSrc/MemWrite/IRWrite/ResultSrc/ALUSrcA/ALUSrcB/ALUControl/RegWrite/ImmSrc drive the datapath;
//        IllegalInstr pulses in DECODE on an unsupported opcode; State is the debug state code;
//        Retired counts completed instructions (wraps modulo 2^RETIRE_W).
// Build option: define MC_JAL_EN to support jal (DECODE->JAL->ALUWB); otherwise jal decodes as illegal.
module multicycle_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         Instr,
  input  logic                Zero,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [2:0]          ALUControl,
  output logic                RegWrite,
  output logic [1:0]          ImmSrc,
  output logic                IllegalInstr,
  output logic [3:0]          State,
  output logic [RETIRE_W-1:0] Retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

`ifdef MC_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  state_t              r_state;
  state_t              w_next;
  logic [RETIRE_W-1:0] r_retired;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_pcwrite, w_adrsrc, w_memwrite, w_irwrite, w_regwrite, w_illegal, w_retire;
  logic [1:0] w_resultsrc, w_alusrca, w_alusrcb, w_immsrc;
  logic [2:0] w_aluctl, w_alu_dec;
  logic       w_unused;

  assign w_opcode = Instr[6:0];
  assign w_funct3 = Instr[14:12];
  // Register/immediate fields are consumed by the datapath, not here.
  assign w_unused = ^{Instr[31], Instr[29:15], Instr[11:7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
    end
  end

  // ALU op for EXECR/EXECI; only R-type honours Instr[30] (sub), addi stays add.
  always_comb begin
    w_alu_dec = 3'b000;
    case (w_funct3)
      3'b000:  if (w_opcode == OP_R && Instr[30]) w_alu_dec = 3'b001;
      3'b010:  w_alu_dec = 3'b101;
      3'b110:  w_alu_dec = 3'b011;
      3'b111:  w_alu_dec = 3'b010;
      default: w_alu_dec = 3'b000;
    endcase
  end

  // Sign-extender format follows the opcode in every state.
  always_comb begin
    w_immsrc = 2'b00;
    case (w_opcode)
      OP_SW:   w_immsrc = 2'b01;
      OP_BEQ:  w_immsrc = 2'b10;
      OP_JAL:  w_immsrc = JAL_EN ? 2'b11 : 2'b00;
      default: w_immsrc = 2'b00;
    endcase
  end

  always_comb begin
    w_next      = S_FETCH;
    w_pcwrite   = 1'b0;
    w_adrsrc    = 1'b0;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_resultsrc = 2'b00;
    w_alusrca   = 2'b00;
    w_alusrcb   = 2'b00;
    w_aluctl    = 3'b000;
    w_regwrite  = 1'b0;
    w_illegal   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        w_pcwrite   = 1'b1;
        w_next      = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes OldPC + imm so BEQ/JAL find the target in ALUOut.
        w_alusrca = 2'b01;
        w_alusrcb = 2'b01;
        case (w_opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL: begin
            if (JAL_EN) w_next = S_JAL;
            else        w_illegal = 1'b1;
          end
          default:      w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_next    = (w_opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adrsrc = 1'b1;
        w_next   = S_MEMWB;
      end
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regwrite  = 1'b1;
        w_retire    = 1'b1;
      end
      S_MEMWRITE: begin
        w_adrsrc   = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_EXECR: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b00;
        w_aluctl  = w_alu_dec;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_aluctl  = w_alu_dec;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      S_BEQ: begin
        w_alusrca = 2'b10;
        w_alusrcb = 2'b00;
        w_aluctl  = 3'b001;
        w_pcwrite = Zero;
        w_retire  = 1'b1;
      end
      S_JAL: begin
        // ALUResult = OldPC + 4 is the link value; PC loads the target from ALUOut.
        w_alusrca = 2'b01;
        w_alusrcb = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Enables are masked by rst so nothing is written while reset is held.
  assign PCWrite      = w_pcwrite  & ~rst;
  assign MemWrite     = w_memwrite & ~rst;
  assign IRWrite      = w_irwrite  & ~rst;
  assign RegWrite     = w_regwrite & ~rst;
  assign IllegalInstr = w_illegal  & ~rst;
  assign AdrSrc       = w_adrsrc;
  assign ResultSrc    = w_resultsrc;
  assign ALUSrcA      = w_alusrca;
  assign ALUSrcB      = w_alusrcb;
  assign ALUControl   = w_aluctl;
  assign ImmSrc       = w_immsrc;
  assign State        = r_state;
  assign Retired      = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected per-cycle control words queued at issue, compared each cycle.
// Latency: one record per DUT cycle of each instruction.
// No backpressure: the controller advances every cycle.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Instr = 32'h0;
  logic        Zero = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalInstr;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;
  logic [31:0] Retired;

  multicycle_ctrl #(.RETIRE_W(32)) dut (
    .clk(clk), .rst(rst), .Instr(Instr), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .IllegalInstr(IllegalInstr), .State(State),
    .Retired(Retired)
  );

  always #5 clk = ~clk;

`ifdef MC_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, memw, irw;
    logic [1:0] res, srca, srcb;
    logic [2:0] aluc;
    logic       regw;
    logic [1:0] imm;
    logic       ill;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       c;
    logic [31:0] ret;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_ret = 0;
  exp_t        m_e;
  ctrl_t       m_a;

  function automatic ctrl_t mk(input logic [3:0] st, input logic pcw, adr, memw, irw,
                               input logic [1:0] res, srca, srcb, input logic [2:0] aluc,
                               input logic regw, input logic [1:0] imm, input logic ill);
    ctrl_t c;
    c = '{st, pcw, adr, memw, irw, res, srca, srcb, aluc, regw, imm, ill};
    return c;
  endfunction

  // Monitor: one expected control word per cycle while work is queued.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      m_a = '{State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
              ALUControl, RegWrite, ImmSrc, IllegalInstr};
      total++;
      if (m_a !== m_e.c) begin
        bad++;
        $display("FAIL ctrl state=%0d actual=%h required=%h (instr=%h zero=%b)",
                 m_e.c.st, m_a, m_e.c, Instr, Zero);
      end
      total++;
      if (Retired !== m_e.ret) begin
        bad++;
        $display("FAIL retired state=%0d actual=%0d required=%0d", m_e.c.st, Retired, m_e.ret);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [31:0] i);
    case (i[14:12])
      3'b000:  return (i[6:0] == 7'b0110011 && i[30]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Reference: instruction class -> list of per-cycle control words.
  task automatic issue(input logic [31:0] ins, input logic z);
    ctrl_t    seq[$];
    logic [1:0] imm;
    logic       retires;
    logic [6:0] op;
    op = ins[6:0];
    retires = 1'b1;
    case (op)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = JAL_EN ? 2'b11 : 2'b00;
      default:    imm = 2'b00;
    endcase
    seq.push_back(mk(4'd0, 1,0,0,1, 2'b10, 2'b00, 2'b10, 3'b000, 0, imm, 0));
    case (op)
      7'b0000011: begin
        seq.push_back(mk(4'd1, 0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 0, imm, 0));
        seq.push_back(mk(4'd2, 0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 0, imm, 0));
        seq.push_back(mk(4'd3, 0,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 0, imm, 0));
        seq.push_back(mk(4'd4, 0,0,0,0, 2'b01, 2'b00, 2'b00, 3'b000, 1, imm, 0));
      end
      7'b0100011: begin
        seq.push_back(mk(4'd1, 0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 0, imm, 0));
        seq.push_back(mk(4'd2, 0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 0, imm, 0));
        seq.push_back(mk(4'd5, 0,1,1,0, 2'b00, 2'b00, 2'b00, 3'b000, 0, imm, 0));
      end
      7'b0110011, 7'b0010011: begin
        seq.push_back(mk(4'd1, 0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 0, imm, 0));
        if (op == 7'b0110011)
          seq.push_back(mk(4'd6, 0,0,0,0, 2'b00, 2'b10, 2'b00, alu_of(ins), 0, imm, 0));
        else
          seq.push_back(mk(4'd7, 0,0,0,0, 2'b00, 2'b10, 2'b01, alu_of(ins), 0, imm, 0));
        seq.push_back(mk(4'd8, 0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 1, imm, 0));
      end
      7'b1100011: begin
        seq.push_back(mk(4'd1, 0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 0, imm, 0));
        seq.push_back(mk(4'd9, z,0,0,0, 2'b00, 2'b10, 2'b00, 3'b001, 0, imm, 0));
      end
      default: begin
        if (op == 7'b1101111 && JAL_EN) begin
          seq.push_back(mk(4'd1,  0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 0, imm, 0));
          seq.push_back(mk(4'd10, 1,0,0,0, 2'b00, 2'b01, 2'b10, 3'b000, 0, imm, 0));
          seq.push_back(mk(4'd8,  0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 1, imm, 0));
        end else begin
          seq.push_back(mk(4'd1, 0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 0, imm, 1));
          retires = 1'b0;
        end
      end
    endcase
    Instr = ins;
    Zero  = z;
    foreach (seq[k]) q.push_back('{seq[k], model_ret});
    if (retires) model_ret = model_ret + 1;
    repeat (seq.size()) @(posedge clk);
    #1;
  endtask

  // Reset arriving in MEMWB of a lw: the write must be suppressed and the count cleared.
  task automatic mid_reset();
    Instr = 32'h00802283;
    Zero  = 1'b0;
    q.push_back('{mk(4'd0, 1,0,0,1, 2'b10, 2'b00, 2'b10, 3'b000, 0, 2'b00, 0), model_ret});
    q.push_back('{mk(4'd1, 0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 0, 2'b00, 0), model_ret});
    q.push_back('{mk(4'd2, 0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 0, 2'b00, 0), model_ret});
    q.push_back('{mk(4'd3, 0,1,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 0, 2'b00, 0), model_ret});
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_memwb_state", {28'h0, State}, 32'd4);
    chk("rst_memwb_regwrite", {31'h0, RegWrite}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_ret = 0;
  endtask

  function automatic bit legal_op(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 || op == 7'b0010011 ||
           op == 7'b1100011 || (op == 7'b1101111 && JAL_EN);
  endfunction

  initial begin
    logic [6:0]  ops[7];
    logic [31:0] r;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b0};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {28'h0, State}, 32'd0);
    chk("reset_retired", Retired, 32'd0);
    chk("reset_enables", {28'h0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
    chk("reset_illegal", {31'h0, IllegalInstr}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    issue(32'h00802283, 1'b0);
    issue(32'h00502223, 1'b0);
    issue(32'h002081B3, 1'b0);
    issue(32'h402081B3, 1'b0);
    issue(32'h00000463, 1'b1);
    issue(32'h00000463, 1'b0);
    issue(32'hFFFFFFFF, 1'b1);
    issue(32'h008000EF, 1'b0);
    issue(32'h40002013, 1'b0);
    mid_reset();

    for (int n = 0; n < 300; n++) begin
      int k;
      k = $urandom_range(0, 6);
      r = $urandom;
      if (k == 6) begin
        while (legal_op(r[6:0])) r = $urandom;
      end else begin
        r[6:0] = ops[k];
      end
      issue(r, 1'($urandom_range(0, 1)));
    end

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
